seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_if.sv | 22 ++
 rtl/seg_scan_decoder.sv | 151 +++++++++++++++
 tb/tb_seg_scan_decoder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Bundle between a multiplexed 7-segment scan source and the scan decoder.
// master drives the display lines; slave decodes them and reports frames.
interface seg_scan_if;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        changed;
    logic        timeout;

    modport master (
        output an, seg,
        input  value, digit_err, blank, frame_valid, changed, timeout
    );

    modport slave (
        input  an, seg,
        output value, digit_err, blank, frame_valid, changed, timeout
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Recovers a 4-digit hex value by watching a multiplexed, active-low
// 7-segment display: each digit is captured once it has settled, then published as a frame.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]    CAP_AT  = 8'(SETTLE_CYCLES - 2);
    localparam logic [7:0]    CNT_MAX = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYCLES);

    // Returns {hit, nibble}; a miss yields nibble 0, which is what gets stored.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0010000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b0100111: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = 5'b0_0000;
        endcase
    endfunction

    logic [10:0]   prev;
    logic [7:0]    stable_cnt;
    logic [3:0]    mask;
    logic [15:0]   sh_nib;
    logic [3:0]    sh_err;
    logic [3:0]    sh_blank;
    logic          first_frame;
    logic [TW-1:0] tcnt;
    logic [15:0]   value_q;
    logic [3:0]    err_q;
    logic [3:0]    blank_q;
    logic          frame_valid_q;
    logic          changed_q;

    logic          an_ok;
    logic [1:0]    dig;
    logic          same;
    logic          cap;
    logic [4:0]    dec;
    logic          seg_blank;
    logic [15:0]   sh_nib_n;
    logic [3:0]    sh_err_n;
    logic [3:0]    sh_blank_n;
    logic [3:0]    mask_n;
    logic          publish;

    // NOTE: every always_comb output gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        an_ok      = 1'b1;
        dig        = 2'd0;
        sh_nib_n   = sh_nib;
        sh_err_n   = sh_err;
        sh_blank_n = sh_blank;
        mask_n     = mask;

        case (bus.an)
            4'b1110: dig = 2'd0;
            4'b1101: dig = 2'd1;
            4'b1011: dig = 2'd2;
            4'b0111: dig = 2'd3;
            default: an_ok = 1'b0;
        endcase

        same      = ({bus.an, bus.seg} == prev);
        // The counter parks at CNT_MAX, so a long dwell crosses CAP_AT only once.
        cap       = an_ok && same && (stable_cnt == CAP_AT);
        dec       = decode(bus.seg);
        seg_blank = (bus.seg == 7'b1111111);

        if (cap) begin
            sh_nib_n[{dig, 2'b00} +: 4] = dec[3:0];
            sh_err_n[dig]               = !dec[4] && !seg_blank;
            sh_blank_n[dig]             = seg_blank;
            mask_n[dig]                 = 1'b1;
        end

        publish = cap && (mask_n == 4'b1111);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev          <= '0;
            stable_cnt    <= '0;
            mask          <= '0;
            // NOTE: the shadows are a handful of flops, not a RAM, so they reset like the rest of the state.
            sh_nib        <= '0;
            sh_err        <= '0;
            sh_blank      <= '0;
            first_frame   <= 1'b1;
            tcnt          <= '0;
            value_q       <= '0;
            err_q         <= '0;
            blank_q       <= '0;
            frame_valid_q <= 1'b0;
            changed_q     <= 1'b0;
        end else begin
            prev <= {bus.an, bus.seg};

            if (!an_ok || !same)
                stable_cnt <= '0;
            else if (stable_cnt != CNT_MAX)
                stable_cnt <= stable_cnt + 8'd1;

            sh_nib   <= sh_nib_n;
            sh_err   <= sh_err_n;
            sh_blank <= sh_blank_n;
            mask     <= publish ? 4'b0000 : mask_n;

            frame_valid_q <= publish;
            changed_q     <= publish && (first_frame || (sh_nib_n != value_q));

            if (publish) begin
                value_q     <= sh_nib_n;
                err_q       <= sh_err_n;
                blank_q     <= sh_blank_n;
                first_frame <= 1'b0;
            end

            if (publish)
                tcnt <= '0;
            else if (tcnt != T_MAX)
                tcnt <= tcnt + TW'(1);
        end
    end

    assign bus.value       = value_q;
    assign bus.digit_err   = err_q;
    assign bus.blank       = blank_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.changed     = changed_q;
    assign bus.timeout     = (tcnt == T_MAX);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: scripted display scans, with expected frames queued
// as each scan is driven and compared when the decoder publishes them.
module tb_seg_scan_decoder;
    localparam int S = 4;
    localparam int T = 64;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  err;
        logic [3:0]  blank;
        logic        changed;
    } frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if bus();

    seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] pat [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
    };

    frame_t      q[$];
    frame_t      got_exp;
    int          n_checks      = 0;
    int          n_pass        = 0;
    int          frames_seen   = 0;
    int          frames_pushed = 0;
    logic [15:0] model_prev    = '0;
    bit          model_first   = 1'b1;
    bit          fv_last       = 1'b0;

    function automatic frame_t model(input logic [3:0][6:0] p);
        frame_t f;
        f = '0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] nib;
            bit hit;
            nib = 4'h0;
            hit = 1'b0;
            for (int n = 0; n < 16; n++)
                if (p[k] == pat[n]) begin
                    nib = n[3:0];
                    hit = 1'b1;
                end
            f.value[4*k +: 4] = nib;
            f.blank[k]        = (p[k] == 7'b1111111);
            f.err[k]          = !hit && !f.blank[k];
        end
        return f;
    endfunction

    task automatic push_expected(input logic [3:0][6:0] p);
        frame_t f;
        f           = model(p);
        f.changed   = model_first || (f.value != model_prev);
        model_prev  = f.value;
        model_first = 1'b0;
        q.push_back(f);
        frames_pushed++;
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        bus.an  = a;
        bus.seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [3:0][6:0] p);
        for (int k = 0; k < 3; k++) hold(4'(~(4'b0001 << k)), p[k], S);
        push_expected(p);
        hold(4'b0111, p[3], S);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() != 0 || frames_seen != frames_pushed)
            $display("FAIL %s frames: seen=%0d pending=%0d required seen=%0d pending=0",
                     name, frames_seen, q.size(), frames_pushed);
        else n_pass++;
    endtask

    task automatic apply_reset();
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        model_first = 1'b1;
        model_prev  = '0;
    endtask

    // Scoreboard side: every published frame must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && bus.frame_valid) begin
            frames_seen++;
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_frame: value=%h, none expected", bus.value);
            end else begin
                got_exp = q.pop_front();
                if (bus.value !== got_exp.value)
                    $display("FAIL value: got %h expected %h", bus.value, got_exp.value);
                else if (bus.digit_err !== got_exp.err)
                    $display("FAIL digit_err: got %b expected %b", bus.digit_err, got_exp.err);
                else if (bus.blank !== got_exp.blank)
                    $display("FAIL blank: got %b expected %b", bus.blank, got_exp.blank);
                else if (bus.changed !== got_exp.changed)
                    $display("FAIL changed: got %b expected %b", bus.changed, got_exp.changed);
                else n_pass++;
            end
        end
        if (rst_n && fv_last) begin
            n_checks++;
            if (bus.frame_valid !== 1'b0 || bus.changed !== 1'b0)
                $display("FAIL pulse_width: frame_valid=%b changed=%b expected 0 0",
                         bus.frame_valid, bus.changed);
            else n_pass++;
        end
        fv_last = rst_n && bus.frame_valid;
    end

    task automatic test_reset();
        n_checks++;
        if ({bus.value, bus.digit_err, bus.blank, bus.frame_valid, bus.changed, bus.timeout} !== '0)
            $display("FAIL reset_state: value=%h err=%b blank=%b fv=%b ch=%b to=%b expected all 0",
                     bus.value, bus.digit_err, bus.blank, bus.frame_valid, bus.changed, bus.timeout);
        else n_pass++;
    endtask

    task automatic test_timeout();
        repeat (T - 1) @(posedge clk);
        #1;
        n_checks++;
        if (bus.timeout !== 1'b0) $display("FAIL timeout_early: got %b expected 0", bus.timeout);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (bus.timeout !== 1'b1) $display("FAIL timeout_edge: got %b expected 1", bus.timeout);
        else n_pass++;
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (bus.timeout !== 1'b1) $display("FAIL timeout_hold: got %b expected 1", bus.timeout);
        else n_pass++;
    endtask

    task automatic test_basic();
        scan({pat[4], pat[3], pat[2], pat[1]});
        n_checks++;
        if (bus.frame_valid !== 1'b1 || bus.timeout !== 1'b0)
            $display("FAIL publish_edge: fv=%b timeout=%b expected 1 0", bus.frame_valid, bus.timeout);
        else n_pass++;
        drain("basic");
    endtask

    task automatic test_repeat();
        scan({pat[4], pat[3], pat[2], pat[1]});
        drain("repeat");
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (bus.value !== 16'h4321) $display("FAIL value_hold: got %h expected 4321", bus.value);
        else n_pass++;
    endtask

    task automatic test_short_dwell();
        hold(4'b1110, pat[5], S);
        hold(4'b1101, pat[6], S);
        hold(4'b1011, pat[8], S - 1);
        hold(4'b1111, 7'b1111111, 5);
        hold(4'b0111, pat[9], S);
        hold(4'b1111, 7'b1111111, 5);
        drain("short_dwell_no_frame");
        push_expected({pat[9], pat[7], pat[6], pat[5]});
        hold(4'b1011, pat[7], S);
        drain("short_dwell");
    endtask

    task automatic test_blank_err();
        scan({pat[15], 7'b1111111, 7'b1010101, pat[10]});
        drain("blank_err");
    endtask

    task automatic test_invalid_an();
        hold(4'b1110, pat[5], S);
        hold(4'b1110, pat[6], S);
        hold(4'b1100, pat[14], 100);
        hold(4'b1101, pat[7], S);
        hold(4'b1111, pat[14], 100);
        hold(4'b1011, pat[8], S);
        hold(4'b1100, pat[14], 100);
        drain("invalid_an_no_frame");
        push_expected({pat[9], pat[8], pat[7], pat[6]});
        hold(4'b0111, pat[9], S);
        drain("invalid_an");
    endtask

    task automatic test_reset_midframe();
        hold(4'b1110, pat[0], S);
        hold(4'b1101, pat[0], S);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.value, bus.digit_err, bus.blank, bus.frame_valid, bus.changed, bus.timeout} !== '0)
            $display("FAIL async_reset: value=%h err=%b blank=%b fv=%b ch=%b to=%b expected all 0",
                     bus.value, bus.digit_err, bus.blank, bus.frame_valid, bus.changed, bus.timeout);
        else n_pass++;
        @(posedge clk); #1;
        rst_n       = 1'b1;
        model_first = 1'b1;
        model_prev  = '0;
        hold(4'b1011, pat[0], S);
        hold(4'b0111, pat[0], S);
        hold(4'b1111, 7'b1111111, 5);
        drain("midframe_discard");
        hold(4'b1110, pat[0], S);
        push_expected({pat[0], pat[0], pat[0], pat[0]});
        hold(4'b1101, pat[0], S);
        drain("first_after_reset");
        scan({pat[0], pat[0], pat[0], pat[0]});
        drain("zero_repeat");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        apply_reset();
        test_reset();
        test_timeout();
        test_basic();
        test_repeat();
        test_short_dwell();
        test_blank_err();
        test_invalid_an();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
